// File: rtl/unsigned_64d32_seq_div.sv
// rtl/unsigned_64d32_seq_div.sv - sequential restoring divider, 64-bit dividend by 32-bit divisor
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready operand handshake; z (64b dividend) and y (32b divisor)
//                       are latched on the accepting edge
//   out_valid/out_ready result handshake; q quotient, r remainder, ovf set when
//                       the quotient does not fit in 32 bits or y == 0
//
// Build option:
//   UNSIGNED_DIV_TRUNC_L10_EN  run only 22 iterations, producing q[31:10];
//                              q[9:0] and r read as zero. Overflow path unchanged.

module unsigned_64d32_seq_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] z,
  input  logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        ovf
);

`ifdef UNSIGNED_DIV_TRUNC_L10_EN
  localparam int QW = 22;
`else
  localparam int QW = 32;
`endif
  localparam logic [5:0] ITERS = 6'(QW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [32:0]    rem;       // partial remainder, always < divisor between steps
  logic [31:0]    dvd_lo;    // low dividend word, shifted out MSB first
  logic [31:0]    dvs;
  logic [QW-1:0]  quo;
  logic [5:0]     cnt;
  logic           ovf_pend;  // overflow detected at accept; reported on the next edge

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [33:0]    rem_sh;
  logic [32:0]    diff;
  logic           fits;
  logic [32:0]    rem_nx;
  logic [QW-1:0]  quo_nx;

  always_comb begin
    rem_sh = {rem, dvd_lo[31]};
    fits   = rem_sh >= {2'b00, dvs};
    // Only used when fits, so the result is below dvs and 33 bits suffice.
    diff   = rem_sh[32:0] - {1'b0, dvs};
    rem_nx = fits ? diff : rem_sh[32:0];
    quo_nx = {quo[QW-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      q         <= '0;
      r         <= '0;
      ovf       <= 1'b0;
      rem       <= '0;
      dvd_lo    <= '0;
      dvs       <= '0;
      quo       <= '0;
      cnt       <= '0;
      ovf_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= CALC;
            in_ready <= 1'b0;
            rem      <= {1'b0, z[63:32]};
            dvd_lo   <= z[31:0];
            dvs      <= y;
            quo      <= '0;
            cnt      <= ITERS;
            ovf_pend <= (y == 32'd0) || (z[63:32] >= y);
          end
        end

        CALC: begin
          if (ovf_pend) begin
            // dvd_lo still holds z[31:0] since no step has run.
            state     <= DONE;
            out_valid <= 1'b1;
            q         <= 32'hFFFF_FFFF;
            r         <= dvd_lo;
            ovf       <= 1'b1;
            ovf_pend  <= 1'b0;
          end else begin
            rem    <= rem_nx;
            dvd_lo <= {dvd_lo[30:0], 1'b0};
            quo    <= quo_nx;
            cnt    <= cnt - 6'd1;
            if (cnt == 6'd1) begin
              state     <= DONE;
              out_valid <= 1'b1;
              ovf       <= 1'b0;
`ifdef UNSIGNED_DIV_TRUNC_L10_EN
              q         <= {quo_nx, 10'd0};
              r         <= '0;
`else
              q         <= quo_nx;
              r         <= rem_nx[31:0];
`endif
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_64d32_seq_div.sv
// tb/tb_unsigned_64d32_seq_div.sv - self-checking bench for unsigned_64d32_seq_div

module tb_unsigned_64d32_seq_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] z;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic [31:0] r;
  logic        ovf;

  int checks = 0;
  int errors = 0;

`ifdef UNSIGNED_DIV_TRUNC_L10_EN
  localparam bit TRUNC = 1'b1;
  localparam int CALC_LAT = 22;
`else
  localparam bit TRUNC = 1'b0;
  localparam int CALC_LAT = 32;
`endif

  unsigned_64d32_seq_div dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] zz;
    logic [31:0] yy;
    logic [31:0] eq;   // exact-mode expectations
    logic [31:0] er;
    logic        eovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Exact expectation -> what the configured mode should report.
  task automatic mode_adjust(inout logic [31:0] eq, inout logic [31:0] er, input logic eovf);
    if (TRUNC && !eovf) begin
      eq = eq & 32'hFFFF_FC00;
      er = 32'd0;
    end
  endtask

  // Reference: plain 64-bit arithmetic.
  task automatic ref_div(input logic [63:0] zz, input logic [31:0] yy,
                         output logic [31:0] eq, output logic [31:0] er, output logic eovf);
    logic [63:0] qq;
    logic [63:0] rr;
    if (yy == 32'd0 || (zz >> 32) >= {32'd0, yy}) begin
      eq = 32'hFFFF_FFFF;
      er = zz[31:0];
      eovf = 1'b1;
    end else begin
      qq = zz / {32'd0, yy};
      rr = zz % {32'd0, yy};
      eq = qq[31:0];
      er = rr[31:0];
      eovf = 1'b0;
    end
    mode_adjust(eq, er, eovf);
  endtask

  // One full transaction; inputs change #1 after an edge, outputs sampled there too.
  task automatic do_op(input logic [63:0] zz, input logic [31:0] yy,
                       input logic [31:0] eq, input logic [31:0] er, input logic eovf,
                       input bit stall);
    int n;
    logic [31:0] hq, hr;
    logic        hovf;
    in_valid  = 1'b1;
    z         = zz;
    y         = yy;
    out_ready = 1'b0;
    @(posedge clk); #1;                       // E0
    in_valid = 1'b0;
    check("in_ready_busy", {63'd0, in_ready}, 64'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid = 1'($urandom_range(0, 1));    // must be ignored in CALC
      z = {$urandom(), $urandom()};
      y = $urandom();
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("latency", 64'(n), 64'(eovf ? 1 : CALC_LAT));
    check("q", {32'd0, q}, {32'd0, eq});
    check("r", {32'd0, r}, {32'd0, er});
    check("ovf", {63'd0, ovf}, {63'd0, eovf});
    if (stall) begin
      hq = q; hr = r; hovf = ovf;
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'b1;
        z = {$urandom(), $urandom()};
        y = $urandom();
        @(posedge clk); #1;
        check("stall_q", {32'd0, q}, {32'd0, hq});
        check("stall_r", {32'd0, r}, {32'd0, hr});
        check("stall_ovf", {63'd0, ovf}, {63'd0, hovf});
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        check("stall_out_valid", {63'd0, out_valid}, 64'd1);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_in_ready", {63'd0, in_ready}, 64'd1);
    check("hs_out_valid", {63'd0, out_valid}, 64'd0);
    check("hold_after_q", {32'd0, q}, {32'd0, eq});
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] eq, er, ry, zh;
    logic        eovf;
    logic [63:0] rz;

    vecs.push_back('{64'd100, 32'd7, 32'd14, 32'd2, 1'b0});
    vecs.push_back('{64'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1});
    vecs.push_back('{64'h0000_0005_0000_0000, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b1});
    vecs.push_back('{64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0});
    vecs.push_back('{64'd35000, 32'd7, 32'd5000, 32'd0, 1'b0});
    vecs.push_back('{64'd0, 32'd1, 32'd0, 32'd0, 1'b0});
    vecs.push_back('{64'h0000_0000_FFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0});
    vecs.push_back('{64'h0000_0001_0000_0000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1});
    vecs.push_back('{64'h0000_0006_0000_0003, 32'd6, 32'hFFFF_FFFF, 32'd3, 1'b1});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; z = '0; y = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_q", {32'd0, q}, 64'd0);
    check("rst_r", {32'd0, r}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);

    foreach (vecs[i]) begin
      eq = vecs[i].eq; er = vecs[i].er; eovf = vecs[i].eovf;
      mode_adjust(eq, er, eovf);
      do_op(vecs[i].zz, vecs[i].yy, eq, er, eovf, 1'b0);
    end

    // Long stall in DONE with in_valid held high.
    ref_div(64'h0000_0003_1234_5678, 32'h0000_0010, eq, er, eovf);
    do_op(64'h0000_0003_1234_5678, 32'h0000_0010, eq, er, eovf, 1'b1);

    // Abort in CALC: rst on E10.
    in_valid = 1'b1; z = 64'd100; y = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_q", {32'd0, q}, 64'd0);
    check("abort_r", {32'd0, r}, 64'd0);
    ref_div(64'd100, 32'd7, eq, er, eovf);
    do_op(64'd100, 32'd7, eq, er, eovf, 1'b0);

    // Reset wins over a simultaneous accept.
    in_valid = 1'b1; z = 64'd100; y = 32'd7; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_prio_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    check("rst_prio_idle", {63'd0, in_ready}, 64'd1);
    check("rst_prio_out_valid", {63'd0, out_valid}, 64'd0);

    // Randomized operands against the arithmetic reference.
    for (int k = 0; k < 40; k++) begin
      ry = $urandom();
      if (k % 8 == 3) ry = 32'd0;
      else if (k % 4 == 1) ry = $urandom_range(1, 255);
      if (k % 5 == 4 || ry == 32'd0) zh = $urandom();
      else zh = $urandom() % ry;
      rz = {zh, $urandom()};
      ref_div(rz, ry, eq, er, eovf);
      do_op(rz, ry, eq, er, eovf, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unsigned_64d32_seq_div.md
UNSIGNED_64D32_SEQ_DIV -- requirements
Module: unsigned_64d32_seq_div

Interface
REQ-001 The block SHALL use one clock and one reset: reset is synchronous and active-high, ports named clk and rst.
REQ-002 The block SHALL have the following ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: operand pair offered.
- in_ready, output, 1: block can accept operands.
- z, input, 64: unsigned dividend (a product word).
- y, input, 32: unsigned divisor.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts result.
- q, output, 32: unsigned quotient.
- r, output, 32: unsigned remainder.
- ovf, output, 1: quotient not representable in 32 bits, or divide by zero.

Function
REQ-003 The block SHALL be a three-state FSM: IDLE, CALC, DONE.
REQ-004 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both SHALL be registered.
REQ-005 Accept SHALL occur on an edge where in_valid=1 and in_ready=1; z and y SHALL be latched on that edge (edge E0).
REQ-006 At accept, if y==0 or z[63:32]>=y, the FSM SHALL go to DONE at E1 with ovf=1, q=32'hFFFFFFFF, r=z[31:0].
REQ-007 Otherwise the FSM SHALL enter CALC: restoring radix-2 division, one quotient bit per edge, MSB first, using a 33-bit partial remainder initialised from z[63:32].
REQ-008 Exact mode SHALL run 32 iterations on edges E1..E32 and enter DONE at E32 with q=floor(z/y), r=z mod y, ovf=0.
REQ-009 q, r and ovf SHALL update only on entry to DONE and SHALL hold stable while in DONE and afterwards until the next DONE entry.
REQ-010 On an edge where out_valid=1 and out_ready=1, the FSM SHALL return to IDLE; a new accept SHALL NOT occur on that same edge.
REQ-011 While in CALC, in_valid SHALL be ignored and the FSM SHALL NOT stall.
REQ-012 The iteration counter SHALL be 6 bits and count down; no wrap-around SHALL be reachable.

Reset
REQ-013 When rst=1 on an edge, the block SHALL go to IDLE from any state, aborting an in-flight CALC or pending DONE without producing a result.
REQ-014 After reset: in_ready=1, out_valid=0, q=0, r=0, ovf=0, with internal remainder and counter cleared.
REQ-015 rst SHALL take priority over a simultaneous accept or handshake.

Configuration
REQ-016 Macro UNSIGNED_DIV_TRUNC_L10_EN SHALL select the truncated mode.
REQ-017 When UNSIGNED_DIV_TRUNC_L10_EN is defined:
- CALC SHALL run 22 iterations (E1..E22), producing only q[31:10].
- q[9:0] SHALL be 0 and r SHALL be 0.
- DONE SHALL be entered at E22.
- The overflow path SHALL be unchanged.
REQ-018 When UNSIGNED_DIV_TRUNC_L10_EN is undefined, exact 32-iteration behaviour SHALL apply, as in REQ-008.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- z=100, y=7, out_ready=1 -> out_valid high after E32; q=14, r=2, ovf=0; in_ready high the cycle after the handshake.
- z=5, y=0 -> out_valid after E1; ovf=1, q=32'hFFFFFFFF, r=5.
- z=64'h00000005_00000000, y=5 -> ovf=1 after E1; z=64'hFFFFFFFE_00000001, y=32'hFFFFFFFF -> q=32'hFFFFFFFF, r=0, ovf=0.
- out_ready held 0 for 10 cycles in DONE -> q/r/ovf stable, in_ready=0, in_valid ignored; handshake on out_ready=1 -> IDLE next edge.
- rst=1 at E10 of CALC -> next cycle in_ready=1, out_valid=0, q=r=0; a following z=100, y=7 completes normally.
- With UNSIGNED_DIV_TRUNC_L10_EN: z=35000, y=7 -> out_valid after E22; q=4096, r=0, ovf=0.
